// File: rtl/accum_xcel_pkg.sv
// Shared types and constants for the accumulator accelerator.
// Build option: ACCUM_XCEL_BASE_ADDR_EN (used by accum_xcel_dpath / accum_xcel_fsm)
// adds a base_addr_i port that offsets every request address.
package accum_xcel_pkg;

    localparam int unsigned ADDR_NBITS = 16;
    localparam int unsigned DATA_NBITS = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/accum_xcel_dpath.sv
// Datapath of the accumulator accelerator: word index, latched size, running sum,
// held result and request address generation.
// Build option: ACCUM_XCEL_BASE_ADDR_EN adds base_addr_i (latched on start, low two
// bits forced to zero) and offsets the address by it, wrapping at 16 bits.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start_i         accepted go: latch size (and base), clear index/sum/result
//   step_i          one accumulate beat (CALC)
//   size_i          word count to latch on start
//   base_addr_i     byte base address (option only)
//   memresp_data_i  read data for the current beat
//   idx_last_o      current beat is the final one
//   addr_o          byte address of the current beat
//   result_o        held sum of the completed run
module accum_xcel_dpath
    import accum_xcel_pkg::*;
#(
    parameter int unsigned p_size_nbits = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    step_i,
    input  logic [p_size_nbits-1:0] size_i,
`ifdef ACCUM_XCEL_BASE_ADDR_EN
    input  logic [ADDR_NBITS-1:0]   base_addr_i,
`endif
    input  logic [DATA_NBITS-1:0]   memresp_data_i,
    output logic                    idx_last_o,
    output logic [ADDR_NBITS-1:0]   addr_o,
    output logic [DATA_NBITS-1:0]   result_o
);

    localparam logic [p_size_nbits-1:0] SizeOne = p_size_nbits'(1);

    logic [p_size_nbits-1:0] idx_q, idx_d;
    logic [p_size_nbits-1:0] size_q, size_d;
    logic [DATA_NBITS-1:0]   accum_q, accum_d;
    logic [DATA_NBITS-1:0]   result_q, result_d;
    logic [DATA_NBITS-1:0]   sum;
    logic [ADDR_NBITS-1:0]   offset;
`ifdef ACCUM_XCEL_BASE_ADDR_EN
    logic [ADDR_NBITS-1:0]   base_q, base_d;
`endif

    // Carry out of bit 31 is intentionally dropped.
    assign sum        = accum_q + memresp_data_i;
    assign idx_last_o = (idx_q == (size_q - SizeOne));
    assign offset     = ADDR_NBITS'({idx_q, 2'b00});

`ifdef ACCUM_XCEL_BASE_ADDR_EN
    assign addr_o = base_q + offset;
`else
    assign addr_o = offset;
`endif

    assign result_o = result_q;

    always_comb begin
        idx_d    = idx_q;
        size_d   = size_q;
        accum_d  = accum_q;
        result_d = result_q;
`ifdef ACCUM_XCEL_BASE_ADDR_EN
        base_d   = base_q;
`endif
        if (start_i) begin
            idx_d    = '0;
            size_d   = size_i;
            accum_d  = '0;
            result_d = '0;
`ifdef ACCUM_XCEL_BASE_ADDR_EN
            base_d   = {base_addr_i[ADDR_NBITS-1:2], 2'b00};
`endif
        end else if (step_i) begin
            idx_d   = idx_q + SizeOne;
            accum_d = sum;
            // Result only updates on the final beat so it reads 0 throughout CALC.
            if (idx_last_o) begin
                result_d = sum;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            size_q   <= '0;
            accum_q  <= '0;
            result_q <= '0;
`ifdef ACCUM_XCEL_BASE_ADDR_EN
            base_q   <= '0;
`endif
        end else begin
            idx_q    <= idx_d;
            size_q   <= size_d;
            accum_q  <= accum_d;
            result_q <= result_d;
`ifdef ACCUM_XCEL_BASE_ADDR_EN
            base_q   <= base_d;
`endif
        end
    end

endmodule

// File: rtl/accum_xcel_fsm.sv
// Accumulator accelerator top: reads `size` consecutive words from the data memory
// (one per cycle, same-cycle response) and holds their 32-bit sum with a done flag.
// Build option: ACCUM_XCEL_BASE_ADDR_EN adds base_addr_i to offset all addresses.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   go_i            start pulse, honoured only in IDLE or DONE
//   size_i          number of words to sum, latched on accepted go
//   base_addr_i     byte base address (option only)
//   memreq_val_o    read request valid (CALC only)
//   memreq_addr_o   byte address of the request, 0 when not requesting
//   memresp_data_i  read data, valid in the same cycle as the request
//   result_o        accumulated sum
//   done_o          high while in DONE
module accum_xcel_fsm
    import accum_xcel_pkg::*;
#(
    parameter int unsigned p_size_nbits = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    go_i,
    input  logic [p_size_nbits-1:0] size_i,
`ifdef ACCUM_XCEL_BASE_ADDR_EN
    input  logic [ADDR_NBITS-1:0]   base_addr_i,
`endif
    output logic                    memreq_val_o,
    output logic [ADDR_NBITS-1:0]   memreq_addr_o,
    input  logic [DATA_NBITS-1:0]   memresp_data_i,
    output logic [DATA_NBITS-1:0]   result_o,
    output logic                    done_o
);

    state_e state_q, state_d;

    logic                  start;
    logic                  step;
    logic                  idx_last;
    logic [ADDR_NBITS-1:0] dpath_addr;

    accum_xcel_dpath #(
        .p_size_nbits (p_size_nbits)
    ) u_dpath (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .step_i         (step),
        .size_i         (size_i),
`ifdef ACCUM_XCEL_BASE_ADDR_EN
        .base_addr_i    (base_addr_i),
`endif
        .memresp_data_i (memresp_data_i),
        .idx_last_o     (idx_last),
        .addr_o         (dpath_addr),
        .result_o       (result_o)
    );

    always_comb begin
        state_d       = state_q;
        start         = 1'b0;
        step          = 1'b0;
        memreq_val_o  = 1'b0;
        memreq_addr_o = '0;
        done_o        = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                done_o = (state_q == StDone);
                if (go_i) begin
                    start   = 1'b1;
                    state_d = (size_i == '0) ? StDone : StCalc;
                end
            end
            StCalc: begin
                memreq_val_o  = 1'b1;
                memreq_addr_o = dpath_addr;
                step          = 1'b1;
                if (idx_last) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

endmodule
